// File: rtl/reorder_buffer_n.sv
// Reorder buffer: circular queue of in-flight instructions with multi-port
// result broadcast, in-order commit, full flush and partial squash.

// One ROB slot. Allocation takes priority over a result write. Flush only
// clears the busy bit; a freed slot's payload is never observed.
module rob_entry #(
  parameter int DATA_W = 16,
  parameter int INST_W = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              alloc,
  input  logic [INST_W-1:0] alloc_inst,
  input  logic [2:0]        alloc_dest,
  input  logic              alloc_predict,
  input  logic              wr,
  input  logic [DATA_W-1:0] wr_value,
  input  logic              wr_taken,
  input  logic              kill,
  output logic              busy,
  output logic [DATA_W-1:0] value,
  output logic              taken,
  output logic [INST_W-1:0] inst,
  output logic [2:0]        dest,
  output logic              predict
);

  // Slot state: allocate, complete from the CDB, or drop on squash.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy    <= 1'b0;
      value   <= '0;
      taken   <= 1'b0;
      inst    <= '0;
      dest    <= '0;
      predict <= 1'b0;
    end else if (flush) begin
      busy <= 1'b0;
    end else if (alloc) begin
      busy    <= 1'b1;
      value   <= '0;
      taken   <= 1'b0;
      inst    <= alloc_inst;
      dest    <= alloc_dest;
      predict <= alloc_predict;
    end else if (wr) begin
      busy  <= 1'b0;
      value <= wr_value;
      taken <= wr_taken;
    end else if (kill) begin
      busy <= 1'b0;
    end
  end

endmodule

module reorder_buffer_n #(
  parameter int  DEPTH   = 8,
  parameter int  DATA_W  = 16,
  parameter int  INST_W  = 16,
  parameter int  NUM_CDB = 2,
  localparam int IW      = $clog2(DEPTH)
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      alloc_req,
  input  logic [INST_W-1:0]         alloc_inst,
  input  logic [2:0]                alloc_dest,
  input  logic                      alloc_predict,
  output logic [IW-1:0]             alloc_idx,
  input  logic [NUM_CDB-1:0]        cdb_valid,
  input  logic [NUM_CDB*IW-1:0]     cdb_idx,
  input  logic [NUM_CDB*DATA_W-1:0] cdb_value,
  input  logic [NUM_CDB-1:0]        cdb_taken,
  input  logic                      commit,
  input  logic                      flush,
  input  logic                      squash,
  input  logic [IW-1:0]             squash_idx,
  output logic                      head_ready,
  output logic [IW-1:0]             head_idx,
  output logic [DATA_W-1:0]         head_value,
  output logic [2:0]                head_dest,
  output logic [INST_W-1:0]         head_inst,
  output logic                      head_predict,
  output logic                      head_taken,
  output logic [IW:0]               count,
  output logic                      empty,
  output logic                      full
);

  logic [IW-1:0] head_q, tail_q;
  logic [IW:0]   count_q;

  logic [DEPTH-1:0]             busy;
  logic [DEPTH-1:0][DATA_W-1:0] value;
  logic [DEPTH-1:0]             taken;
  logic [DEPTH-1:0][INST_W-1:0] inst;
  logic [DEPTH-1:0][2:0]        dest;
  logic [DEPTH-1:0]             predict;

  // Squash is honoured only when squash_idx names a live entry; its age
  // offset from head decides which entries survive.
  logic [IW-1:0] sq_off;
  logic          sq_ok, do_alloc, do_commit;

  assign sq_off    = squash_idx - head_q;
  assign sq_ok     = squash && ({1'b0, sq_off} < count_q);
  assign full      = (count_q == (IW+1)'(DEPTH));
  assign empty     = (count_q == '0);
  assign head_ready = !empty && !busy[head_q];
  assign do_alloc  = alloc_req && !full && !sq_ok;
  assign do_commit = commit && head_ready && !sq_ok;

  assign alloc_idx    = tail_q;
  assign count        = count_q;
  assign head_idx     = head_q;
  assign head_value   = value[head_q];
  assign head_dest    = dest[head_q];
  assign head_inst    = inst[head_q];
  assign head_predict = predict[head_q];
  assign head_taken   = taken[head_q];

  // Queue pointers and occupancy; flush beats squash beats alloc/commit.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (flush) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
    end else if (sq_ok) begin
      tail_q  <= squash_idx + IW'(1);
      count_q <= {1'b0, sq_off} + (IW+1)'(1);
    end else begin
      if (do_alloc)  tail_q <= tail_q + IW'(1);
      if (do_commit) head_q <= head_q + IW'(1);
      if (do_alloc && !do_commit)      count_q <= count_q + (IW+1)'(1);
      else if (!do_alloc && do_commit) count_q <= count_q - (IW+1)'(1);
    end
  end

  for (genvar i = 0; i < DEPTH; i++) begin : g_ent
    logic [IW-1:0]     off;
    logic              occ, keep, at_tail, hit, hit_taken;
    logic [DATA_W-1:0] hit_value;

    assign off     = IW'(i) - head_q;
    assign occ     = ({1'b0, off} < count_q);
    assign keep    = !sq_ok || (off <= sq_off);
    assign at_tail = do_alloc && (tail_q == IW'(i));

    // CDB port select for this slot; scanning high to low lets port 0 win.
    always_comb begin
      hit       = 1'b0;
      hit_value = '0;
      hit_taken = 1'b0;
      for (int k = NUM_CDB-1; k >= 0; k--) begin
        if (cdb_valid[k] && (cdb_idx[k*IW +: IW] == IW'(i))) begin
          hit       = 1'b1;
          hit_value = cdb_value[k*DATA_W +: DATA_W];
          hit_taken = cdb_taken[k];
        end
      end
    end

    rob_entry #(.DATA_W(DATA_W), .INST_W(INST_W)) u_ent (
      .clk           (clk),
      .reset         (reset),
      .flush         (flush),
      .alloc         (at_tail),
      .alloc_inst    (alloc_inst),
      .alloc_dest    (alloc_dest),
      .alloc_predict (alloc_predict),
      .wr            (hit && occ && busy[i] && keep && !at_tail),
      .wr_value      (hit_value),
      .wr_taken      (hit_taken),
      .kill          (sq_ok && occ && !keep),
      .busy          (busy[i]),
      .value         (value[i]),
      .taken         (taken[i]),
      .inst          (inst[i]),
      .dest          (dest[i]),
      .predict       (predict[i])
    );
  end

endmodule
